// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared constants and types for the fetch PC controller and its branch predictor.
package fetch_pc_ctrl_pkg;

  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpJal    = 7'h6F;
  localparam logic [6:0] OpJalr   = 7'h67;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic [1:0] {
    CntSnt = 2'b00,
    CntWnt = 2'b01,
    CntWt  = 2'b10,
    CntSt  = 2'b11
  } cnt_e;

  // Saturating 2-bit counter step toward taken (up=1) or not-taken (up=0).
  function automatic cnt_e cnt_step(input cnt_e c, input logic up);
    cnt_e r;
    r = c;
    unique case (c)
      CntSnt: r = up ? CntWnt : CntSnt;
      CntWnt: r = up ? CntWt  : CntSnt;
      CntWt:  r = up ? CntSt  : CntWnt;
      CntSt:  r = up ? CntSt  : CntWt;
      default: r = CntWnt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_bht.sv
// Direct-mapped 2-bit counter table plus BTB: one combinational read port, one synchronous write.
module bht_btb
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int unsigned Entries = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] rd_pc_i,
  output logic        rd_hit_o,
  output cnt_e        rd_cnt_o,
  output logic [31:0] rd_target_o,
  input  logic        we_i,
  input  logic [31:0] wr_pc_i,
  input  logic        wr_taken_i,
  input  logic [31:0] wr_target_i
);

  localparam int unsigned IdxW = $clog2(Entries);
  localparam int unsigned TagW = 32 - IdxW - 2;

  cnt_e              cnt_q    [Entries];
  logic              valid_q  [Entries];
  logic [TagW-1:0]   tag_q    [Entries];
  logic [31:0]       target_q [Entries];

  logic [IdxW-1:0] rd_idx, wr_idx;
  logic [TagW-1:0] rd_tag, wr_tag;
  logic            unused_lsbs;

  assign rd_idx      = rd_pc_i[IdxW+1:2];
  assign rd_tag      = rd_pc_i[31:IdxW+2];
  assign wr_idx      = wr_pc_i[IdxW+1:2];
  assign wr_tag      = wr_pc_i[31:IdxW+2];
  assign unused_lsbs = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  // Reads see registered state, so a same-cycle write to the read index is not visible yet.
  assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_cnt_o    = cnt_q[rd_idx];
  assign rd_target_o = target_q[rd_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Entries); i++) begin
        cnt_q[i]   <= CntWnt;
        valid_q[i] <= 1'b0;
      end
    end else if (we_i) begin
      cnt_q[wr_idx] <= cnt_step(cnt_q[wr_idx], wr_taken_i);
      if (wr_taken_i) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target_i;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register with BHT/BTB next-PC prediction and execute-stage mispredict redirect.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DefaultResetPc,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        ex_valid_i,
  input  logic        ex_ctrl_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic [31:0] pc_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  output logic        flush_o
);

  logic [31:0] pc_q, pc_d;
  logic        rd_hit;
  cnt_e        rd_cnt;
  logic [31:0] rd_target;
  logic        ex_resolve, mispredict, tbl_we;
  logic [31:0] ex_fix_pc;

  bht_btb #(
    .Entries (BHT_ENTRIES)
  ) u_bht_btb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_pc_i     (pc_q),
    .rd_hit_o    (rd_hit),
    .rd_cnt_o    (rd_cnt),
    .rd_target_o (rd_target),
    .we_i        (tbl_we),
    .wr_pc_i     (ex_pc_i),
    .wr_taken_i  (ex_taken_i),
    .wr_target_i (ex_target_i)
  );

  assign ex_resolve = ex_valid_i && ex_ctrl_i;
  assign mispredict = ex_resolve && ((ex_taken_i != ex_pred_taken_i) ||
                                     (ex_taken_i && (ex_target_i != ex_pred_target_i)));
  assign ex_fix_pc  = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
  // Reset on the same edge suppresses the table write.
  assign tbl_we     = ex_resolve && !rst_i;

  always_comb begin
    pc_o          = pc_q;
    pred_taken_o  = rd_hit && ((rd_cnt == CntWt) || (rd_cnt == CntSt));
    pred_target_o = pred_taken_o ? rd_target : pc_q + 32'd4;
    flush_o       = mispredict;
    pc_d          = pred_target_o;
    if (mispredict) begin
      pc_d = ex_fix_pc;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed, table-driven bench for fetch_pc_ctrl: one row per cycle, outputs checked before the edge.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ex_valid, ex_ctrl, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [31:0] pc, pred_target;
  logic        pred_taken, flush;

  int passed;
  int total;

  fetch_pc_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .BHT_ENTRIES (16)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .stall_i          (stall),
    .ex_valid_i       (ex_valid),
    .ex_ctrl_i        (ex_ctrl),
    .ex_taken_i       (ex_taken),
    .ex_pc_i          (ex_pc),
    .ex_target_i      (ex_target),
    .ex_pred_taken_i  (ex_pred_taken),
    .ex_pred_target_i (ex_pred_target),
    .pc_o             (pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .flush_o          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        exv;
    logic        exc;
    logic        ext;
    logic [31:0] expc;
    logic [31:0] extgt;
    logic        expt;
    logic [31:0] exptgt;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic        fl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic s, input logic v, input logic c,
                              input logic t, input logic [31:0] xp, input logic [31:0] xt,
                              input logic xpt, input logic [31:0] xptg, input logic [31:0] epc,
                              input logic ept, input logic [31:0] eptg, input logic efl);
    vec_t x;
    x.rst = r; x.stall = s; x.exv = v; x.exc = c; x.ext = t;
    x.expc = xp; x.extgt = xt; x.expt = xpt; x.exptgt = xptg;
    x.pc = epc; x.pt = ept; x.ptg = eptg; x.fl = efl;
    return x;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic idle_ex();
    ex_valid = 0; ex_ctrl = 0; ex_taken = 0; ex_pred_taken = 0;
    ex_pc = '0; ex_target = '0; ex_pred_target = '0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    stall  = 1'b0;
    idle_ex();

    //       rst stl v  c  t  ex_pc       ex_tgt        ppt pred_tgt     pc            pt  ptg           fl
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'h0,        0, 32'h4,        0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'h0,        0, 32'h4,        0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'h4,        0, 32'h8,        0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'h8,        0, 32'hC,        0));
    // beq @0x10 taken to 0x40, predicted not-taken
    vq.push_back(mk(0, 0, 1, 1, 1, 32'h10,  32'h40,       0, 32'h14,   32'hC,        0, 32'h10,       1));
    // jal @0x3C to 0x10 mispredicted, to get back to 0x10
    vq.push_back(mk(0, 0, 1, 1, 1, 32'h3C,  32'h10,       0, 32'h40,   32'h40,       0, 32'h44,       1));
    // fetch 0x10 predicts taken; second taken resolution (correct) 10->11
    vq.push_back(mk(0, 0, 1, 1, 1, 32'h10,  32'h40,       1, 32'h40,   32'h10,       1, 32'h40,       0));
    // third taken resolution saturates at 11
    vq.push_back(mk(0, 0, 1, 1, 1, 32'h10,  32'h40,       1, 32'h40,   32'h40,       0, 32'h44,       0));
    // bne @0x10 predicted taken, resolves not-taken: 11->10, redirect 0x14
    vq.push_back(mk(0, 0, 1, 1, 0, 32'h10,  32'h40,       1, 32'h40,   32'h44,       0, 32'h48,       1));
    // jalr mispredict under stall: target 0x80, predicted 0x84
    vq.push_back(mk(0, 1, 1, 1, 1, 32'h20,  32'h80,       1, 32'h84,   32'h14,       0, 32'h18,       1));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'h80,       0, 32'h84,       0));
    vq.push_back(mk(0, 0, 1, 1, 1, 32'hC,   32'h10,       0, 32'h10,   32'h80,       0, 32'h84,       1));
    // 0x10 still predicts taken (counter 10); ex_valid=0 resolution must be ignored
    vq.push_back(mk(0, 0, 0, 1, 1, 32'h10,  32'h200,      0, 32'h14,   32'h10,       1, 32'h40,       0));
    // non-control instruction must be ignored
    vq.push_back(mk(0, 0, 1, 0, 1, 32'h10,  32'h300,      0, 32'h14,   32'h40,       0, 32'h44,       0));
    vq.push_back(mk(0, 0, 1, 1, 1, 32'hC,   32'h10,       0, 32'h10,   32'h44,       0, 32'h48,       1));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'h10,       1, 32'h40,       0));
    // redirect to top of address space; entry 0 gets tag of 0x100
    vq.push_back(mk(0, 0, 1, 1, 1, 32'h100, 32'hFFFF_FFFC, 0, 32'h104, 32'h40,       0, 32'h44,       1));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'hFFFF_FFFC, 0, 32'h0,        0));
    // pc 0 shares entry 0 with 0x100 but tag differs
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'h0,        0, 32'h4,        0));
    // reset during a mispredict: flush still visible, redirect and update dropped
    vq.push_back(mk(1, 0, 1, 1, 1, 32'h10,  32'h500,      0, 32'h14,   32'h4,        0, 32'h8,        1));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'h0,        0, 32'h4,        0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'h4,        0, 32'h8,        0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'h8,        0, 32'hC,        0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'hC,        0, 32'h10,       0));
    // table was cleared by reset: 0x10 no longer predicted
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,    32'h10,       0, 32'h14,       0));

    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      rst            = vq[i].rst;
      stall          = vq[i].stall;
      ex_valid       = vq[i].exv;
      ex_ctrl        = vq[i].exc;
      ex_taken       = vq[i].ext;
      ex_pc          = vq[i].expc;
      ex_target      = vq[i].extgt;
      ex_pred_taken  = vq[i].expt;
      ex_pred_target = vq[i].exptgt;
      #1;
      chk32($sformatf("row%0d pc", i), pc, vq[i].pc);
      chk1($sformatf("row%0d pred_taken", i), pred_taken, vq[i].pt);
      chk32($sformatf("row%0d pred_target", i), pred_target, vq[i].ptg);
      chk1($sformatf("row%0d flush", i), flush, vq[i].fl);
      @(posedge clk);
      @(negedge clk);
    end

    // Stall hold across several cycles with no resolution.
    idle_ex();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk32($sformatf("stall%0d pc", k), pc, 32'h14);
      chk1($sformatf("stall%0d flush", k), flush, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk32("stall release pc", pc, 32'h14);
    @(posedge clk);
    #1;
    chk32("after release pc", pc, 32'h18);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
